// File: rtl/tpfu_pkg.sv
// Shared types and constants for the temporally programmed FU sequencer.
// Optional perf counter in the top is enabled by defining TPFU_PERF_CNT_EN.
package tpfu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_MUL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b000101;
    localparam logic [5:0] OP_SUBI = 6'b000110;
    localparam logic [5:0] OP_MULI = 6'b000111;

    // Instruction field boundaries: opcode | dst | src1 | src2/imm
    localparam int OPC_MSB  = 23;
    localparam int OPC_LSB  = 18;
    localparam int DST_MSB  = 17;
    localparam int DST_LSB  = 12;
    localparam int SRC1_MSB = 11;
    localparam int SRC1_LSB = 6;
    localparam int SRC2_MSB = 5;
    localparam int SRC2_LSB = 0;

    localparam int PIPE_LAT_DEF = 4;

endpackage

// File: rtl/tpfu_valid_pipe.sv
// Shift register mirroring the FU pipeline: carries {valid, program index}
// so results can be flagged exactly LAT cycles after issue.
module tpfu_valid_pipe #(
    parameter int LAT   = 4,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_v,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_v,
    output logic [IDX_W-1:0] out_idx,
    output logic             inflight
);

    logic [LAT-1:0]   v_q;
    logic [LAT-1:0]   v_d;
    logic [IDX_W-1:0] idx_q [LAT];
    logic [IDX_W-1:0] idx_d [LAT];

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign v_d[gi]   = in_v;
                assign idx_d[gi] = in_idx;
            end else begin : g_tail
                assign v_d[gi]   = v_q[gi-1];
                assign idx_d[gi] = idx_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
        end else begin
            v_q <= v_d;
            for (int i = 0; i < LAT; i++) idx_q[i] <= idx_d[i];
        end
    end

    // Anything still travelling that has not yet reached the output stage.
    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < LAT - 1; i++) inflight = inflight | v_q[i];
    end

    assign out_v   = v_q[LAT-1];
    assign out_idx = idx_q[LAT-1];

endmodule

// File: rtl/tpfu_sequencer.sv
// Programmable sequencer: captures an input burst into the FU register file,
// then issues the stored program and flags results. Macro: TPFU_PERF_CNT_EN.
module tpfu_sequencer
    import tpfu_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int INST_W     = 24,
    parameter int RF_ADDR_W  = 6,
    parameter int PIPE_LAT   = PIPE_LAT_DEF,
    localparam int PC_W      = $clog2(PROG_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prog_we,
    input  logic [PC_W-1:0]      prog_addr,
    input  logic [INST_W-1:0]    prog_data,
    input  logic [PC_W:0]        prog_len,
    input  logic                 valid,
    output logic                 din_ready,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [INST_W-1:0]    inst,
    output logic                 inst_v,
    output logic                 res_v,
    output logic [PC_W-1:0]      res_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 rf_ovf
`ifdef TPFU_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);

    localparam logic [PC_W:0] LEN_MAX = (PC_W + 1)'(PROG_DEPTH);

    state_t               state_q, state_d;
    logic [PC_W:0]        len_q, len_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [RF_ADDR_W:0]   cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 rdy_q, rdy_d;
    logic                 accept, ovf_now, last_issue, inflight;
    logic [INST_W-1:0]    pmem [PROG_DEPTH];

    // Program memory: written only while idle, read combinationally from pc.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && prog_we) pmem[prog_addr] <= prog_data;
    end

    // rdy_q gates burst acceptance so nothing is taken during or right after reset.
    assign accept     = (state_q == IDLE) && valid && rdy_q;
    assign last_issue = ({1'b0, pc_q} == (len_q - (PC_W + 1)'(1)));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        rf_we    = 1'b0;
        rf_waddr = '0;
        inst_v   = 1'b0;
        ovf_now  = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (accept) begin
                    len_d   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
                    rf_we   = 1'b1;
                    cnt_d   = (RF_ADDR_W + 1)'(1);
                    ovf_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (valid) begin
                    // Counter saturates at 2^RF_ADDR_W; further words are dropped.
                    if (cnt_q[RF_ADDR_W]) begin
                        ovf_now = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        rf_we    = 1'b1;
                        rf_waddr = cnt_q[RF_ADDR_W-1:0];
                        cnt_d    = cnt_q + (RF_ADDR_W + 1)'(1);
                    end
                end else begin
                    state_d = (len_q == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                inst_v = 1'b1;
                pc_d   = pc_q + PC_W'(1);
                if (last_issue) state_d = DRAIN;
            end
            DRAIN: begin
                if (!inflight) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdy_d = (state_d == IDLE) || (state_d == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
        end
    end

    tpfu_valid_pipe #(
        .LAT   (PIPE_LAT),
        .IDX_W (PC_W)
    ) u_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_v     (inst_v),
        .in_idx   (pc_q),
        .out_v    (res_v),
        .out_idx  (res_idx),
        .inflight (inflight)
    );

    assign inst      = inst_v ? pmem[pc_q] : '0;
    assign din_ready = rdy_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign rf_ovf    = ovf_q | ovf_now;

`ifdef TPFU_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (accept) perf_d = '0;
        else if (busy && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule
